// File: rtl/coreaxi4dmacontroller_dscrptr_chunk_scheduler_if.sv
// Bundle of the scheduler's cache-side and engine-side signals.
//   Cache status : slot_valid, slot_rdy (per-slot eligibility inputs)
//   Cache read   : rd_slot -> rd_byte_cnt, rd_src_addr, rd_dst_addr, rd_src_incr, rd_dst_incr
//   Engine       : xfer_req/xfer_ack handshake with xfer_slot/src/dst/len, xfer_done/xfer_err completion
//   Cache update : upd_strb with upd_slot, upd_byte_cnt, upd_src_addr, upd_dst_addr, upd_err
// The master modport is the scheduler; the slave modport is the cache/engine side.
interface coreaxi4dmacontroller_dscrptr_chunk_scheduler_if #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned BYTE_CNT_W = 24,
  parameter int unsigned CHUNK_W    = 13
);
  logic [NUM_SLOTS-1:0]  slot_valid;
  logic [NUM_SLOTS-1:0]  slot_rdy;

  logic [SLOT_W-1:0]     rd_slot;
  logic [BYTE_CNT_W-1:0] rd_byte_cnt;
  logic [31:0]           rd_src_addr;
  logic [31:0]           rd_dst_addr;
  logic                  rd_src_incr;
  logic                  rd_dst_incr;

  logic                  xfer_req;
  logic                  xfer_ack;
  logic [SLOT_W-1:0]     xfer_slot;
  logic [31:0]           xfer_src_addr;
  logic [31:0]           xfer_dst_addr;
  logic [CHUNK_W-1:0]    xfer_len;
  logic                  xfer_done;
  logic                  xfer_err;

  logic                  upd_strb;
  logic [SLOT_W-1:0]     upd_slot;
  logic [BYTE_CNT_W-1:0] upd_byte_cnt;
  logic [31:0]           upd_src_addr;
  logic [31:0]           upd_dst_addr;
  logic                  upd_err;

  modport master (
    input  slot_valid, slot_rdy,
    output rd_slot,
    input  rd_byte_cnt, rd_src_addr, rd_dst_addr, rd_src_incr, rd_dst_incr,
    output xfer_req, xfer_slot, xfer_src_addr, xfer_dst_addr, xfer_len,
    input  xfer_ack, xfer_done, xfer_err,
    output upd_strb, upd_slot, upd_byte_cnt, upd_src_addr, upd_dst_addr, upd_err
  );

  modport slave (
    output slot_valid, slot_rdy,
    input  rd_slot,
    output rd_byte_cnt, rd_src_addr, rd_dst_addr, rd_src_incr, rd_dst_incr,
    input  xfer_req, xfer_slot, xfer_src_addr, xfer_dst_addr, xfer_len,
    output xfer_ack, xfer_done, xfer_err,
    input  upd_strb, upd_slot, upd_byte_cnt, upd_src_addr, upd_dst_addr, upd_err
  );
endinterface

// File: rtl/coreaxi4dmacontroller_dscrptr_chunk_scheduler.sv
// Descriptor chunk scheduler.
// Picks an eligible descriptor-cache slot round-robin, reads it, issues one
// chunk of at most MAX_CHUNK bytes to the transaction engine, and on
// completion writes the remaining byte count and advanced addresses back to
// the cache. A written-back count of 0 retires the slot in the cache.
// Ports:
//   clock    - system clock
//   resetn   - asynchronous active-low reset
//   sched_en - global enable, only looked at while idle
//   busy     - high whenever the scheduler is not idle
//   bus      - cache read/update and engine request/completion signals
module coreaxi4dmacontroller_dscrptr_chunk_scheduler #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned BYTE_CNT_W = 24,
  parameter int unsigned MAX_CHUNK  = 4096,
  parameter int unsigned CHUNK_W    = 13
) (
  input  logic clock,
  input  logic resetn,
  input  logic sched_en,
  output logic busy,
  coreaxi4dmacontroller_dscrptr_chunk_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  logic [2:0]            state;
  logic [SLOT_W-1:0]     last_slot;
  logic [SLOT_W-1:0]     cur_slot;
  logic [BYTE_CNT_W-1:0] cnt;
  logic [31:0]           src;
  logic [31:0]           dst;
  logic                  src_incr;
  logic                  dst_incr;
  logic [CHUNK_W-1:0]    len;

  logic [NUM_SLOTS-1:0]  elig;
  logic [SLOT_W-1:0]     cand;
  logic [SLOT_W-1:0]     pick;
  logic                  found;
  logic [CHUNK_W-1:0]    load_len;
  logic [BYTE_CNT_W-1:0] done_cnt;
  logic [31:0]           next_src;
  logic [31:0]           next_dst;

  assign elig = bus.slot_valid & bus.slot_rdy;

  // Round-robin search starting one past the last serviced slot.
  always_comb begin
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
      cand = SLOT_W'((32'(last_slot) + i) % NUM_SLOTS);
      if (!found && elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Chunk length: compared one bit wider so MAX_CHUNK == 2^BYTE_CNT_W still works.
  always_comb begin
    load_len = '0;
    if ({1'b0, bus.rd_byte_cnt} > (BYTE_CNT_W + 1)'(MAX_CHUNK)) begin
      load_len = CHUNK_W'(MAX_CHUNK);
    end else begin
      load_len = CHUNK_W'(bus.rd_byte_cnt);
    end
  end

  always_comb begin
    done_cnt = cnt - BYTE_CNT_W'(len);
    next_src = src + (src_incr ? 32'(len) : 32'd0);
    next_dst = dst + (dst_incr ? 32'(len) : 32'd0);
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state             <= S_IDLE;
      last_slot         <= SLOT_W'(NUM_SLOTS - 1);
      cur_slot          <= '0;
      cnt               <= '0;
      src               <= '0;
      dst               <= '0;
      src_incr          <= 1'b0;
      dst_incr          <= 1'b0;
      len               <= '0;
      bus.rd_slot       <= '0;
      bus.xfer_req      <= 1'b0;
      bus.xfer_slot     <= '0;
      bus.xfer_src_addr <= '0;
      bus.xfer_dst_addr <= '0;
      bus.xfer_len      <= '0;
      bus.upd_strb      <= 1'b0;
      bus.upd_slot      <= '0;
      bus.upd_byte_cnt  <= '0;
      bus.upd_src_addr  <= '0;
      bus.upd_dst_addr  <= '0;
      bus.upd_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sched_en && (|elig)) begin
            cur_slot    <= pick;
            bus.rd_slot <= pick;
            state       <= S_LOAD;
          end
        end

        S_LOAD: begin
          cnt      <= bus.rd_byte_cnt;
          src      <= bus.rd_src_addr;
          dst      <= bus.rd_dst_addr;
          src_incr <= bus.rd_src_incr;
          dst_incr <= bus.rd_dst_incr;
          len      <= load_len;
          if (bus.rd_byte_cnt == '0) begin
            // Empty descriptor: skip the engine and retire it directly.
            bus.upd_slot     <= cur_slot;
            bus.upd_byte_cnt <= '0;
            bus.upd_src_addr <= bus.rd_src_addr;
            bus.upd_dst_addr <= bus.rd_dst_addr;
            bus.upd_err      <= 1'b0;
            bus.upd_strb     <= 1'b1;
            state            <= S_UPDATE;
          end else begin
            bus.xfer_req      <= 1'b1;
            bus.xfer_slot     <= cur_slot;
            bus.xfer_src_addr <= bus.rd_src_addr;
            bus.xfer_dst_addr <= bus.rd_dst_addr;
            bus.xfer_len      <= load_len;
            state             <= S_REQ;
          end
        end

        S_REQ: begin
          if (bus.xfer_ack) begin
            bus.xfer_req <= 1'b0;
            state        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.xfer_done) begin
            bus.upd_slot     <= cur_slot;
            bus.upd_byte_cnt <= bus.xfer_err ? '0 : done_cnt;
            bus.upd_src_addr <= next_src;
            bus.upd_dst_addr <= next_dst;
            bus.upd_err      <= bus.xfer_err;
            bus.upd_strb     <= 1'b1;
            state            <= S_UPDATE;
          end
        end

        S_UPDATE: begin
          bus.upd_strb <= 1'b0;
          last_slot    <= cur_slot;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
